// File: rtl/parity16_pkg.sv
// Shared constants, column table and check-bit helpers for the 16-bit SECDED word.
// Used by the syndrome unit, the decoder top level and the encoder-side model.
package parity16_pkg;

    localparam int DATA_W = 11;
    localparam int CHK_W  = 5;
    localparam int CW_W   = 16;

    // Syndrome column of each data bit, {s4..s0}
    localparam logic [CHK_W-1:0] COL_D0  = 5'b11111;
    localparam logic [CHK_W-1:0] COL_D1  = 5'b01110;
    localparam logic [CHK_W-1:0] COL_D2  = 5'b10110;
    localparam logic [CHK_W-1:0] COL_D3  = 5'b00111;
    localparam logic [CHK_W-1:0] COL_D4  = 5'b11010;
    localparam logic [CHK_W-1:0] COL_D5  = 5'b01011;
    localparam logic [CHK_W-1:0] COL_D6  = 5'b10011;
    localparam logic [CHK_W-1:0] COL_D7  = 5'b11100;
    localparam logic [CHK_W-1:0] COL_D8  = 5'b01101;
    localparam logic [CHK_W-1:0] COL_D9  = 5'b10101;
    localparam logic [CHK_W-1:0] COL_D10 = 5'b11001;

    // Result bundle held in the output stage
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  syn;
        logic              single;
        logic              chk_only;
        logic              dbl;
    } dec_res_t;

    function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        c[0] = d[0] ^ d[3] ^ d[5] ^ d[6] ^ d[8] ^ d[9] ^ d[10];
        c[1] = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[4] ^ d[5] ^ d[6];
        c[2] = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9];
        c[3] = d[0] ^ d[1] ^ d[4] ^ d[5] ^ d[7] ^ d[8] ^ d[10];
        c[4] = d[0] ^ d[2] ^ d[4] ^ d[6] ^ d[7] ^ d[9] ^ d[10];
        return c;
    endfunction

    // One-hot flip mask for a syndrome that names a data bit, else zero
    function automatic logic [DATA_W-1:0] syn_to_mask(input logic [CHK_W-1:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        case (s)
            COL_D0:  m[0]  = 1'b1;
            COL_D1:  m[1]  = 1'b1;
            COL_D2:  m[2]  = 1'b1;
            COL_D3:  m[3]  = 1'b1;
            COL_D4:  m[4]  = 1'b1;
            COL_D5:  m[5]  = 1'b1;
            COL_D6:  m[6]  = 1'b1;
            COL_D7:  m[7]  = 1'b1;
            COL_D8:  m[8]  = 1'b1;
            COL_D9:  m[9]  = 1'b1;
            COL_D10: m[10] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/parity16_syndrome.sv
// Combinational check-bit recompute and syndrome for one 16-bit codeword.
// Ports: i_cw codeword ([10:0] data, [15:11] check), o_syn syndrome s[4:0].
module parity16_syndrome
    import parity16_pkg::*;
(
    input  logic [CW_W-1:0]  i_cw,
    output logic [CHK_W-1:0] o_syn
);

    logic [CHK_W-1:0] w_chk;

    assign w_chk = calc_chk(i_cw[DATA_W-1:0]);
    assign o_syn = w_chk ^ i_cw[CW_W-1:DATA_W];

endmodule

// File: rtl/dec_parity_16bit.sv
// Two-stage SECDED decoder: stage 1 holds data+syndrome, stage 2 holds the
// corrected result. Ports: in_* / out_* valid-ready streams, flags, counters.
module dec_parity_16bit
    import parity16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   codeword_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [CHK_W-1:0]  syndrome_out,
    output logic              err_single,
    output logic              err_chk_only,
    output logic              err_double,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corrected,
    output logic [CNT_W-1:0]  cnt_uncorrectable
);

    logic              w_s2_adv;
    logic              w_out_fire;
    logic [CHK_W-1:0]  w_syn;
    logic [DATA_W-1:0] w_mask;
    logic              w_wt1;
    logic              w_single;
    dec_res_t          w_res;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [CHK_W-1:0]  r_s1_syn;
    logic              r_s2_valid;
    dec_res_t          r_s2;
    logic [CNT_W-1:0]  r_cnt_corr;
    logic [CNT_W-1:0]  r_cnt_unc;

    parity16_syndrome u_syn (
        .i_cw  (codeword_in),
        .o_syn (w_syn)
    );

    // Stage 1 moves forward exactly when stage 2 can take its word
    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_adv;
    assign w_out_fire = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_syn   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            r_s1_data  <= codeword_in[DATA_W-1:0];
            r_s1_syn   <= w_syn;
        end
    end

    // Column syndromes all have weight >= 3, so a weight-1 syndrome can only
    // be a check-bit hit; any other unmatched nonzero syndrome is uncorrectable.
    always_comb begin
        w_res          = '0;
        w_mask         = syn_to_mask(r_s1_syn);
        w_wt1          = (r_s1_syn != '0) &&
                         ((r_s1_syn & (r_s1_syn - 5'd1)) == '0);
        w_single       = (|w_mask) || w_wt1;
        w_res.data     = r_s1_data ^ w_mask;
        w_res.syn      = r_s1_syn;
        w_res.single   = w_single;
        w_res.chk_only = w_wt1;
        w_res.dbl      = (r_s1_syn != '0) && !w_single;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2       <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else if (cnt_clr) begin
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else begin
            if (w_out_fire && r_s2.single && (r_cnt_corr != '1)) begin
                r_cnt_corr <= r_cnt_corr + CNT_W'(1);
            end
            if (w_out_fire && r_s2.dbl && (r_cnt_unc != '1)) begin
                r_cnt_unc <= r_cnt_unc + CNT_W'(1);
            end
        end
    end

    assign out_valid         = r_s2_valid;
    assign data_out          = r_s2.data;
    assign syndrome_out      = r_s2.syn;
    assign err_single        = r_s2.single;
    assign err_chk_only      = r_s2.chk_only;
    assign err_double        = r_s2.dbl;
    assign cnt_corrected     = r_cnt_corr;
    assign cnt_uncorrectable = r_cnt_unc;

endmodule

// File: doc/dec_parity_16bit.md
Name: dec_parity_16bit

Overview:
- Receive-side SECDED decoder for the 16-bit parity-protected word.
- Accepts a 16-bit codeword of 11 data bits and 5 check bits; recomputes the check bits and forms a 5-bit syndrome.
- Corrects any single-bit error and flags double errors.
- Two-stage valid/ready pipeline with saturating error counters, placed between the link receiver and the data consumer.

Parameters:
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  codeword_in is valid.
- in_ready  output  1  block can accept a codeword this cycle.
- codeword_in  input  16  [10:0] = data d[10:0]; [15:11] = check bits p[4:0].
- out_valid  output  1  decoded result is valid.
- out_ready  input  1  consumer accepts the result.
- data_out  output  11  corrected data.
- syndrome_out  output  5  syndrome s[4:0] of the word.
- err_single  output  1  single error detected and corrected; the error may be a data bit or a check bit.
- err_chk_only  output  1  the corrected single error was in a check bit, so data is unchanged.
- err_double  output  1  uncorrectable error.
- cnt_clr  input  1  clears both counters.
- cnt_corrected  output  CNT_W  count of accepted results with err_single=1.
- cnt_uncorrectable  output  CNT_W  count of accepted results with err_double=1.

Behaviour:
- Check equations (^ = XOR):
  - c0 = d0^d3^d5^d6^d8^d9^d10
  - c1 = d0^d1^d2^d3^d4^d5^d6
  - c2 = d0^d1^d2^d3^d7^d8^d9
  - c3 = d0^d1^d4^d5^d7^d8^d10
  - c4 = d0^d2^d4^d6^d7^d9^d10
- Syndrome: s[i] = c[i] ^ p[i].
- Data-bit syndrome columns {s4..s0}:
  - d0=11111, d1=01110, d2=10110, d3=00111, d4=11010, d5=01011
  - d6=10011, d7=11100, d8=01101, d9=10101, d10=11001
  - All columns have odd weight and are distinct.
- Classification:
  - s=0: clean. All flags 0; data passes through.
  - s matches a data column: flip that data bit; err_single=1.
  - weight(s)=1: check-bit error; err_single=1, err_chk_only=1; data unchanged.
  - s nonzero, even weight: err_double=1; data passes uncorrected.
  - s odd weight, weight ≥3, no column match: err_double=1; data passes uncorrected.
  - err_single and err_double are never both 1.
- Pipeline:
  - Stage 1 registers the codeword and syndrome.
  - Stage 2 registers the corrected data and flags.
  - Latency is 2 cycles from in_valid&&in_ready to out_valid when no backpressure is applied.
  - Throughput is 1 word per cycle.
- Handshake:
  - Transfer occurs when valid&&ready.
  - While out_valid=1 and out_ready=0, the outputs hold stable.
  - Each stage advances when it is empty or the stage downstream advances.
  - in_ready = !s1_valid || s1_advance, combinational from out_ready.
  - No word is dropped or duplicated under any out_ready pattern.
  - out_valid must not depend combinationally on in_valid.
- Counters:
  - Increment on out_valid&&out_ready with the matching flag.
  - Saturate at all-ones.
  - cnt_clr has priority: if it coincides with an increment, the counter becomes 0.
- Reset (rst_n=0 at a clock edge):
  - Stage valids, out_valid, flags, data_out, syndrome_out and counters go to 0.
  - in_ready is 1 from the first cycle after reset deassertion.
  - Reset mid-stream discards in-flight words.
- Flags, data_out and syndrome_out are meaningful only while out_valid=1.

Decomposition:
- Shared package, e.g. parity16_pkg:
  - Constants DATA_W=11, CHK_W=5, CW_W=16.
  - The 11 syndrome-column constants.
  - A check-bit function, also reusable by the encoder-side model in the bench.
- One sub-module, parity16_syndrome: combinational check-bit recompute plus syndrome, instantiated in stage 1.
- Classification and correction stay in the top level.

Test Plan:
- Clean words: 0x0000, 0xF801 (d=0x001) and 0xFFFF (d=0x7FF) with out_ready=1 -> data 0x000 / 0x001 / 0x7FF; syndrome 0; all flags 0; out_valid exactly 2 cycles after each accept.
- Single data error: 0xF800 (d0 flipped in 0xF801) -> data_out=0x001, syndrome=11111, err_single=1; cnt_corrected becomes 1.
- Check-bit error: 0xDFFF (p2 flipped in 0xFFFF) -> data_out=0x7FF, syndrome=00100, err_single=1, err_chk_only=1.
- Double error: 0x0006 (d1 and d2 flipped in 0x0000) -> syndrome=11000, err_double=1, data_out=0x006; cnt_uncorrectable increments.
- Backpressure: stream 8 words with out_ready toggling pseudo-randomly -> all 8 are output in order with correct values; outputs are stable while stalled; in_ready=0 when both stages are full and stalled.
- Counters and reset:
  - Force cnt_corrected to all-ones -> it stays saturated.
  - cnt_clr coinciding with a corrected accept -> counter is 0.
  - rst_n=0 with 2 words in flight -> out_valid=0 next cycle and counters are 0.
